// File: rtl/exc_pkg.sv
// rtl/exc_pkg.sv - shared exception/interrupt types, constants and id-width helper
package exc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_t;

    localparam logic [7:0] LOST_MAX = 8'd255;

    // Never return zero so a two-source build still has a one-bit id.
    function automatic int src_id_w(input int n_src);
        return (n_src > 2) ? $clog2(n_src) : 1;
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// rtl/irq_sync_edge.sv - two-flop synchroniser plus rising-edge detector for one irq line
module irq_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic irq_raw,
    output logic irq_edge
);

    logic sync1;
    logic sync2;
    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= irq_raw;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign irq_edge = sync2 & ~prev;

endmodule

// File: rtl/ext_irq_ctrl.sv
// rtl/ext_irq_ctrl.sv - external interrupt front end: edge latch, priority select, ack/eret handshake
module ext_irq_ctrl
    import exc_pkg::*;
#(
    parameter int N_SRC = 4,
    parameter int ID_W  = src_id_w(N_SRC)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] irq_in,
    input  logic [N_SRC-1:0] irq_mask,
    input  logic             ExtIAck,
    input  logic             ERet,
    input  logic             lost_clr,
    output logic             ExtIRQ,
    output logic [ID_W-1:0]  irq_id,
    output logic [N_SRC-1:0] pending,
    output logic             in_service,
    output logic [7:0]       lost_cnt
);

    // Lowest index wins.
    function automatic logic [ID_W-1:0] prio_enc(input logic [N_SRC-1:0] v);
        logic [ID_W-1:0] id;
        id = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (v[i]) id = ID_W'(i);
        end
        return id;
    endfunction

    irq_state_t        state;
    logic [N_SRC-1:0]  edge_det;
    logic [N_SRC-1:0]  masked;
    logic              any;
    logic [ID_W-1:0]   winner;
    logic              ack_fire;
    logic [N_SRC-1:0]  clr_vec;
    logic [N_SRC-1:0]  drop;
    logic [4:0]        drop_cnt;
    logic [8:0]        lost_sum;

    for (genvar g = 0; g < N_SRC; g++) begin : g_sync
        irq_sync_edge u_sync (
            .clk      (clk),
            .rst_n    (reset),
            .irq_raw  (irq_in[g]),
            .irq_edge (edge_det[g])
        );
    end

    always_comb begin
        masked   = pending & irq_mask;
        any      = |masked;
        winner   = prio_enc(masked);
        ack_fire = (state == REQ) && ExtIAck;
        clr_vec  = '0;
        drop_cnt = '0;
        for (int i = 0; i < N_SRC; i++) begin
            clr_vec[i] = ack_fire && any && (winner == ID_W'(i));
        end
        // A fresh edge on the bit being acked re-arms it rather than counting as lost.
        drop = edge_det & pending & ~clr_vec;
        for (int i = 0; i < N_SRC; i++) begin
            drop_cnt = drop_cnt + 5'(drop[i]);
        end
        lost_sum = {1'b0, lost_cnt} + 9'(drop_cnt);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clr_vec) | edge_det;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lost_cnt <= '0;
        end else if (lost_clr) begin
            lost_cnt <= '0;
        end else if (lost_sum > {1'b0, LOST_MAX}) begin
            lost_cnt <= LOST_MAX;
        end else begin
            lost_cnt <= lost_sum[7:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            ExtIRQ     <= 1'b0;
            in_service <= 1'b0;
            irq_id     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    irq_id <= winner;
                    if (any) begin
                        state  <= REQ;
                        ExtIRQ <= 1'b1;
                    end
                end
                REQ: begin
                    irq_id <= winner;
                    if (ExtIAck) begin
                        state      <= SERVICE;
                        ExtIRQ     <= 1'b0;
                        in_service <= 1'b1;
                    end else if (!any) begin
                        state  <= IDLE;
                        ExtIRQ <= 1'b0;
                    end
                end
                SERVICE: begin
                    if (ERet) begin
                        state      <= IDLE;
                        in_service <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    ExtIRQ     <= 1'b0;
                    in_service <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ext_irq_ctrl.sv
// tb/tb_ext_irq_ctrl.sv - self-checking bench for ext_irq_ctrl
module tb_ext_irq_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] irq_in;
    logic [3:0] irq_mask;
    logic       ExtIAck;
    logic       ERet;
    logic       lost_clr;
    logic       ExtIRQ;
    logic [1:0] irq_id;
    logic [3:0] pending;
    logic       in_service;
    logic [7:0] lost_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] irq_in;
        logic [3:0] mask;
        logic       ack;
        logic       eret;
        logic       clr;
        int         n;
        logic       ext;
        logic [1:0] id;
        logic [3:0] pend;
        logic       svc;
        logic [7:0] lost;
    } vec_t;

    typedef struct {
        string      tag;
        logic       ext;
        logic [1:0] id;
        logic [3:0] pend;
        logic       svc;
        logic [7:0] lost;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    ext_irq_ctrl #(.N_SRC(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .irq_in     (irq_in),
        .irq_mask   (irq_mask),
        .ExtIAck    (ExtIAck),
        .ERet       (ERet),
        .lost_clr   (lost_clr),
        .ExtIRQ     (ExtIRQ),
        .irq_id     (irq_id),
        .pending    (pending),
        .in_service (in_service),
        .lost_cnt   (lost_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic ext, input logic [1:0] id,
                            input logic [3:0] pend, input logic svc, input logic [7:0] lost);
        exp_t e;
        e.tag = tag; e.ext = ext; e.id = id; e.pend = pend; e.svc = svc; e.lost = lost;
        sb.push_back(e);
    endtask

    task automatic compare_dut();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: got empty queue expected an entry");
        end else begin
            e = sb.pop_front();
            check({e.tag, ".ExtIRQ"},     32'(ExtIRQ),     32'(e.ext));
            check({e.tag, ".irq_id"},     32'(irq_id),     32'(e.id));
            check({e.tag, ".pending"},    32'(pending),    32'(e.pend));
            check({e.tag, ".in_service"}, 32'(in_service), 32'(e.svc));
            check({e.tag, ".lost_cnt"},   32'(lost_cnt),   32'(e.lost));
        end
    endtask

    function automatic vec_t mk(input logic [3:0] i_irq, input logic [3:0] i_mask,
                                input logic i_ack, input logic i_eret, input logic i_clr,
                                input int i_n, input logic e_ext, input logic [1:0] e_id,
                                input logic [3:0] e_pend, input logic e_svc);
        vec_t v;
        v.irq_in = i_irq; v.mask = i_mask; v.ack = i_ack; v.eret = i_eret; v.clr = i_clr;
        v.n = i_n; v.ext = e_ext; v.id = e_id; v.pend = e_pend; v.svc = e_svc; v.lost = 8'd0;
        return v;
    endfunction

    initial begin
        // single request on line 2
        vecs.push_back(mk(4'b0000, 4'hF, 0, 0, 0, 1, 0, 2'd0, 4'b0000, 0));
        vecs.push_back(mk(4'b0100, 4'hF, 0, 0, 0, 1, 0, 2'd0, 4'b0000, 0));
        vecs.push_back(mk(4'b0100, 4'hF, 0, 0, 0, 1, 0, 2'd0, 4'b0000, 0));
        vecs.push_back(mk(4'b0100, 4'hF, 0, 0, 0, 1, 0, 2'd0, 4'b0100, 0));
        vecs.push_back(mk(4'b0100, 4'hF, 0, 0, 0, 1, 1, 2'd2, 4'b0100, 0));
        vecs.push_back(mk(4'b0100, 4'hF, 1, 0, 0, 1, 0, 2'd2, 4'b0000, 1));
        vecs.push_back(mk(4'b0100, 4'hF, 0, 0, 0, 3, 0, 2'd2, 4'b0000, 1));
        vecs.push_back(mk(4'b0100, 4'hF, 0, 1, 0, 1, 0, 2'd2, 4'b0000, 0));
        vecs.push_back(mk(4'b0000, 4'hF, 0, 0, 0, 3, 0, 2'd0, 4'b0000, 0));
        // priority: lines 3 and 1 together
        vecs.push_back(mk(4'b1010, 4'hF, 0, 0, 0, 4, 1, 2'd1, 4'b1010, 0));
        vecs.push_back(mk(4'b1010, 4'hF, 1, 0, 0, 1, 0, 2'd1, 4'b1000, 1));
        vecs.push_back(mk(4'b1010, 4'hF, 0, 1, 0, 1, 0, 2'd1, 4'b1000, 0));
        vecs.push_back(mk(4'b1010, 4'hF, 0, 0, 0, 1, 1, 2'd3, 4'b1000, 0));
        vecs.push_back(mk(4'b1010, 4'hF, 1, 0, 0, 1, 0, 2'd3, 4'b0000, 1));
        vecs.push_back(mk(4'b1010, 4'hF, 0, 1, 0, 1, 0, 2'd3, 4'b0000, 0));
        vecs.push_back(mk(4'b0000, 4'hF, 0, 0, 0, 3, 0, 2'd0, 4'b0000, 0));
        // mask withdrawal on line 0
        vecs.push_back(mk(4'b0001, 4'hF, 0, 0, 0, 4, 1, 2'd0, 4'b0001, 0));
        vecs.push_back(mk(4'b0001, 4'hE, 0, 0, 0, 1, 0, 2'd0, 4'b0001, 0));
        vecs.push_back(mk(4'b0001, 4'hF, 0, 0, 0, 1, 1, 2'd0, 4'b0001, 0));
        vecs.push_back(mk(4'b0001, 4'hF, 1, 0, 0, 1, 0, 2'd0, 4'b0000, 1));
        vecs.push_back(mk(4'b0001, 4'hF, 0, 1, 0, 1, 0, 2'd0, 4'b0000, 0));
        vecs.push_back(mk(4'b0000, 4'hF, 0, 0, 0, 3, 0, 2'd0, 4'b0000, 0));

        reset = 1'b0; irq_in = '0; irq_mask = 4'hF; ExtIAck = 0; ERet = 0; lost_clr = 0;
        tick(); tick();
        push_exp("reset", 0, 2'd0, 4'b0000, 0, 8'd0);
        compare_dut();
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            irq_in = vecs[i].irq_in; irq_mask = vecs[i].mask;
            ExtIAck = vecs[i].ack; ERet = vecs[i].eret; lost_clr = vecs[i].clr;
            push_exp($sformatf("row%0d", i), vecs[i].ext, vecs[i].id, vecs[i].pend,
                     vecs[i].svc, vecs[i].lost);
            repeat (vecs[i].n) tick();
            compare_dut();
        end
        ExtIAck = 0; ERet = 0; lost_clr = 0;

        // lost edges on masked-off line 1
        irq_mask = 4'b1101;
        for (int e = 0; e < 300; e++) begin
            irq_in[1] = 1'b1; tick(); tick();
            irq_in[1] = 1'b0; tick(); tick();
            if (e == 9) begin
                push_exp("lost10", 0, 2'd0, 4'b0010, 0, 8'd9);
                compare_dut();
            end
        end
        push_exp("lost_sat", 0, 2'd0, 4'b0010, 0, 8'd255);
        compare_dut();
        lost_clr = 1'b1; tick(); lost_clr = 1'b0;
        push_exp("lost_clr", 0, 2'd0, 4'b0010, 0, 8'd0);
        compare_dut();
        irq_in[1] = 1'b1; tick(); tick();
        lost_clr = 1'b1; tick(); lost_clr = 1'b0;
        push_exp("clr_vs_drop", 0, 2'd0, 4'b0010, 0, 8'd0);
        compare_dut();
        irq_in[1] = 1'b0; tick(); tick();
        irq_in[1] = 1'b1; tick(); tick(); tick();
        push_exp("lost_one", 0, 2'd0, 4'b0010, 0, 8'd1);
        compare_dut();

        // clean restart, then collision of new line-2 edge with its ack
        reset = 1'b0; irq_in = '0; irq_mask = 4'hF;
        tick(); tick();
        reset = 1'b1; tick();
        irq_in[2] = 1'b1;
        repeat (4) tick();
        push_exp("coll_req", 1, 2'd2, 4'b0100, 0, 8'd0);
        compare_dut();
        irq_in[2] = 1'b0; tick(); tick();
        irq_in[2] = 1'b1; tick(); tick();
        ExtIAck = 1'b1; tick(); ExtIAck = 1'b0;
        push_exp("collision", 0, 2'd2, 4'b0100, 1, 8'd0);
        compare_dut();

        // asynchronous reset while in service
        #2 reset = 1'b0;
        #1;
        push_exp("async_rst", 0, 2'd0, 4'b0000, 0, 8'd0);
        compare_dut();
        tick(); tick();
        reset = 1'b1;
        push_exp("rst_release", 0, 2'd0, 4'b0000, 0, 8'd0);
        compare_dut();
        repeat (4) tick();
        push_exp("high_at_release", 1, 2'd2, 4'b0100, 0, 8'd0);
        compare_dut();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
